// File: rtl/frame_sched.sv
// Frame scheduler: starts and stops a frame-tick generator, turns each tick into one
// frame fetch, and counts completed fetches and ticks dropped because a fetch ran long.
module frame_sched #(
    parameter int FRAME_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               play,
    input  logic               pause,
    input  logic               stop,
    input  logic [FRAME_W-1:0] num_frames,
    output logic               tick_start,
    output logic               tick_stop,
    input  logic               frame,
    output logic               fetch_req,
    output logic [FRAME_W-1:0] fetch_idx,
    input  logic               fetch_ack,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        FETCH    = 3'd2,
        PAUSED   = 3'd3,
        STOPPING = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] limit_q, limit_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0] fetch_idx_q, fetch_idx_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic               pending_q, pending_d;
    logic               kick_q, kick_d;
    logic               pause_mem_q, pause_mem_d;
    logic               fetch_req_q, fetch_req_d;
    logic               tick_start_q, tick_start_d;
    logic               tick_stop_q, tick_stop_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               drop_hit;
    logic               eff_pend;
    logic [FRAME_W-1:0] cnt_next;

    assign cnt_next = frame_cnt_q + 1'b1;
    // A tick arriving in FETCH (even in the ack cycle) is pending once completion is seen.
    assign eff_pend = pending_q | frame;

    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        frame_cnt_d  = frame_cnt_q;
        fetch_idx_d  = fetch_idx_q;
        drop_cnt_d   = drop_cnt_q;
        pending_d    = pending_q;
        kick_d       = kick_q;
        pause_mem_d  = pause_mem_q;
        fetch_req_d  = fetch_req_q;
        tick_start_d = 1'b0;
        tick_stop_d  = 1'b0;
        done_d       = 1'b0;
        drop_hit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop && !pause && play) begin
                    limit_d      = num_frames;
                    frame_cnt_d  = '0;
                    drop_cnt_d   = '0;
                    pending_d    = 1'b0;
                    kick_d       = 1'b0;
                    pause_mem_d  = 1'b0;
                    tick_start_d = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    tick_stop_d = 1'b1;
                    kick_d      = 1'b0;
                    state_d     = IDLE;
                end else if (pause) begin
                    tick_stop_d = 1'b1;
                    pending_d   = pending_q | kick_q;
                    kick_d      = 1'b0;
                    state_d     = PAUSED;
                end else if (frame || kick_q || pending_q) begin
                    fetch_req_d = 1'b1;
                    fetch_idx_d = frame_cnt_q;
                    pending_d   = frame & (kick_q | pending_q);
                    kick_d      = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                drop_hit  = frame & pending_q;
                pending_d = eff_pend;
                if (stop) begin
                    pause_mem_d = 1'b0;
                    if (fetch_ack) begin
                        fetch_req_d = 1'b0;
                        frame_cnt_d = cnt_next;
                        tick_stop_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = STOPPING;
                    end
                end else if (fetch_ack) begin
                    fetch_req_d = 1'b0;
                    frame_cnt_d = cnt_next;
                    pause_mem_d = 1'b0;
                    if (limit_q != '0 && cnt_next == limit_q) begin
                        tick_stop_d = 1'b1;
                        done_d      = 1'b1;
                        pending_d   = 1'b0;
                        state_d     = IDLE;
                    end else if (pause_mem_q || pause) begin
                        tick_stop_d = 1'b1;
                        state_d     = PAUSED;
                    end else begin
                        // Spend one cycle in RUN so fetch_req drops between fetches.
                        kick_d    = eff_pend;
                        pending_d = 1'b0;
                        state_d   = RUN;
                    end
                end else if (pause) begin
                    pause_mem_d = 1'b1;
                end
            end
            STOPPING: begin
                if (fetch_ack) begin
                    fetch_req_d = 1'b0;
                    frame_cnt_d = cnt_next;
                    tick_stop_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            PAUSED: begin
                if (stop) begin
                    tick_stop_d = 1'b1;
                    state_d     = IDLE;
                end else if (!pause && play) begin
                    tick_start_d = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop_hit && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            limit_q      <= '0;
            frame_cnt_q  <= '0;
            fetch_idx_q  <= '0;
            drop_cnt_q   <= '0;
            pending_q    <= 1'b0;
            kick_q       <= 1'b0;
            pause_mem_q  <= 1'b0;
            fetch_req_q  <= 1'b0;
            tick_start_q <= 1'b0;
            tick_stop_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            frame_cnt_q  <= frame_cnt_d;
            fetch_idx_q  <= fetch_idx_d;
            drop_cnt_q   <= drop_cnt_d;
            pending_q    <= pending_d;
            kick_q       <= kick_d;
            pause_mem_q  <= pause_mem_d;
            fetch_req_q  <= fetch_req_d;
            tick_start_q <= tick_start_d;
            tick_stop_q  <= tick_stop_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign tick_start = tick_start_q;
    assign tick_stop  = tick_stop_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_idx  = fetch_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: each task drives one scenario and checks its outputs inline.
module tb_frame_sched;

    localparam int FRAME_W = 16;
    localparam int DROP_W  = 8;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_FETCH    = 3'd2;
    localparam logic [2:0] S_PAUSED   = 3'd3;
    localparam logic [2:0] S_STOPPING = 3'd4;

    logic               CLK = 1'b0;
    logic               RST;
    logic               play, pause, stop, frame, fetch_ack;
    logic [FRAME_W-1:0] num_frames;
    logic               tick_start, tick_stop, fetch_req, busy, done;
    logic [FRAME_W-1:0] fetch_idx, frame_cnt;
    logic [DROP_W-1:0]  drop_cnt;
    logic [2:0]         state_dbg;

    int n_vec = 0;
    int n_err = 0;

    frame_sched #(.FRAME_W(FRAME_W), .DROP_W(DROP_W)) dut (
        .CLK(CLK), .RST(RST), .play(play), .pause(pause), .stop(stop),
        .num_frames(num_frames), .tick_start(tick_start), .tick_stop(tick_stop),
        .frame(frame), .fetch_req(fetch_req), .fetch_idx(fetch_idx),
        .fetch_ack(fetch_ack), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1ns after a rising edge; outputs are read at the same point.
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_play(input logic [FRAME_W-1:0] n);
        num_frames = n;
        play = 1'b1;
        cycle();
        play = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #2 RST = 1'b0;
        repeat (3) cycle();
        n_vec++;
        if (fetch_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tick_start !== 1'b0 || tick_stop !== 1'b0) begin
            $display("FAIL reset_ctl: req=%b busy=%b done=%b ts=%b tp=%b, want all 0", fetch_req, busy, done, tick_start, tick_stop);
            n_err++;
        end
        n_vec++;
        if (frame_cnt !== '0 || drop_cnt !== '0 || fetch_idx !== '0 || state_dbg !== S_IDLE) begin
            $display("FAIL reset_cnt: fc=%0d dc=%0d idx=%0d st=%0d, want 0", frame_cnt, drop_cnt, fetch_idx, state_dbg);
            n_err++;
        end
        RST = 1'b1;
    endtask

    task automatic test_limit_run();
        start_play(16'd3);
        n_vec++;
        if (tick_start !== 1'b1 || busy !== 1'b1 || state_dbg !== S_RUN) begin
            $display("FAIL limit_start: ts=%b busy=%b st=%0d, want 1 1 %0d", tick_start, busy, state_dbg, S_RUN);
            n_err++;
        end
        for (int k = 0; k < 3; k++) begin
            repeat (99) cycle();
            frame = 1'b1;
            cycle();
            frame = 1'b0;
            n_vec++;
            if (fetch_req !== 1'b1 || fetch_idx !== k[FRAME_W-1:0]) begin
                $display("FAIL limit_req%0d: req=%b idx=%0d, want 1 %0d", k, fetch_req, fetch_idx, k);
                n_err++;
            end
            repeat (4) cycle();
            n_vec++;
            if (fetch_req !== 1'b1 || fetch_idx !== k[FRAME_W-1:0]) begin
                $display("FAIL limit_hold%0d: req=%b idx=%0d, want 1 %0d", k, fetch_req, fetch_idx, k);
                n_err++;
            end
            fetch_ack = 1'b1;
            cycle();
            fetch_ack = 1'b0;
            if (k < 2) begin
                n_vec++;
                if (fetch_req !== 1'b0 || frame_cnt !== FRAME_W'(k + 1) || done !== 1'b0 || tick_stop !== 1'b0) begin
                    $display("FAIL limit_ack%0d: req=%b fc=%0d done=%b tp=%b, want 0 %0d 0 0", k, fetch_req, frame_cnt, done, tick_stop, k + 1);
                    n_err++;
                end
            end else begin
                n_vec++;
                if (tick_stop !== 1'b1 || done !== 1'b1 || frame_cnt !== 16'd3 || busy !== 1'b0 || fetch_req !== 1'b0) begin
                    $display("FAIL limit_end: tp=%b done=%b fc=%0d busy=%b req=%b, want 1 1 3 0 0", tick_stop, done, frame_cnt, busy, fetch_req);
                    n_err++;
                end
            end
        end
        cycle();
        n_vec++;
        if (done !== 1'b0 || tick_stop !== 1'b0 || frame_cnt !== 16'd3 || state_dbg !== S_IDLE) begin
            $display("FAIL limit_after: done=%b tp=%b fc=%0d st=%0d, want 0 0 3 %0d", done, tick_stop, frame_cnt, state_dbg, S_IDLE);
            n_err++;
        end
    endtask

    task automatic test_overrun();
        start_play(16'd0);
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame = 1'b1;
            cycle();
            frame = 1'b0;
            cycle();
        end
        n_vec++;
        if (drop_cnt !== 8'd2 || fetch_req !== 1'b1 || fetch_idx !== 16'd0) begin
            $display("FAIL overrun_drop: dc=%0d req=%b idx=%0d, want 2 1 0", drop_cnt, fetch_req, fetch_idx);
            n_err++;
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b0 || frame_cnt !== 16'd1) begin
            $display("FAIL overrun_ack: req=%b fc=%0d, want 0 1", fetch_req, frame_cnt);
            n_err++;
        end
        cycle();
        n_vec++;
        if (fetch_req !== 1'b1 || fetch_idx !== 16'd1 || drop_cnt !== 8'd2) begin
            $display("FAIL overrun_next: req=%b idx=%0d dc=%0d, want 1 1 2", fetch_req, fetch_idx, drop_cnt);
            n_err++;
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || tick_stop !== 1'b1 || frame_cnt !== 16'd2) begin
            $display("FAIL overrun_stop: busy=%b tp=%b fc=%0d, want 0 1 2", busy, tick_stop, frame_cnt);
            n_err++;
        end
    endtask

    task automatic test_tick_ack_same();
        start_play(16'd0);
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        cycle();
        frame = 1'b1;
        fetch_ack = 1'b1;
        cycle();
        frame = 1'b0;
        fetch_ack = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b0 || drop_cnt !== 8'd0 || frame_cnt !== 16'd1) begin
            $display("FAIL tickack_gap: req=%b dc=%0d fc=%0d, want 0 0 1", fetch_req, drop_cnt, frame_cnt);
            n_err++;
        end
        cycle();
        n_vec++;
        if (fetch_req !== 1'b1 || fetch_idx !== 16'd1) begin
            $display("FAIL tickack_next: req=%b idx=%0d, want 1 1", fetch_req, fetch_idx);
            n_err++;
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_pause_fetch();
        start_play(16'd0);
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        pause = 1'b1;
        cycle();
        pause = 1'b0;
        n_vec++;
        if (tick_stop !== 1'b0 || fetch_req !== 1'b1 || state_dbg !== S_FETCH) begin
            $display("FAIL pause_wait: tp=%b req=%b st=%0d, want 0 1 %0d", tick_stop, fetch_req, state_dbg, S_FETCH);
            n_err++;
        end
        cycle();
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        n_vec++;
        if (tick_stop !== 1'b1 || state_dbg !== S_PAUSED || frame_cnt !== 16'd1 || fetch_req !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL pause_ack: tp=%b st=%0d fc=%0d req=%b busy=%b, want 1 %0d 1 0 1", tick_stop, state_dbg, frame_cnt, fetch_req, busy, S_PAUSED);
            n_err++;
        end
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        cycle();
        n_vec++;
        if (fetch_req !== 1'b0 || drop_cnt !== 8'd0 || state_dbg !== S_PAUSED) begin
            $display("FAIL pause_tick: req=%b dc=%0d st=%0d, want 0 0 %0d", fetch_req, drop_cnt, state_dbg, S_PAUSED);
            n_err++;
        end
        play = 1'b1;
        cycle();
        play = 1'b0;
        n_vec++;
        if (tick_start !== 1'b1 || state_dbg !== S_RUN || frame_cnt !== 16'd1) begin
            $display("FAIL pause_resume: ts=%b st=%0d fc=%0d, want 1 %0d 1", tick_start, state_dbg, frame_cnt, S_RUN);
            n_err++;
        end
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b1 || fetch_idx !== 16'd1) begin
            $display("FAIL pause_next: req=%b idx=%0d, want 1 1", fetch_req, fetch_idx);
            n_err++;
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_stop_priority();
        start_play(16'd0);
        stop = 1'b1;
        play = 1'b1;
        cycle();
        stop = 1'b0;
        play = 1'b0;
        n_vec++;
        if (tick_stop !== 1'b1 || tick_start !== 1'b0 || busy !== 1'b0 || state_dbg !== S_IDLE) begin
            $display("FAIL stop_prio: tp=%b ts=%b busy=%b st=%0d, want 1 0 0 %0d", tick_stop, tick_start, busy, state_dbg, S_IDLE);
            n_err++;
        end
        start_play(16'd0);
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        n_vec++;
        if (state_dbg !== S_STOPPING || fetch_req !== 1'b1 || tick_stop !== 1'b0) begin
            $display("FAIL stopping_hold: st=%0d req=%b tp=%b, want %0d 1 0", state_dbg, fetch_req, tick_stop, S_STOPPING);
            n_err++;
        end
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        n_vec++;
        if (tick_stop !== 1'b1 || done !== 1'b0 || frame_cnt !== 16'd1 || fetch_req !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL stopping_ack: tp=%b done=%b fc=%0d req=%b busy=%b, want 1 0 1 0 0", tick_stop, done, frame_cnt, fetch_req, busy);
            n_err++;
        end
    endtask

    task automatic test_drop_saturate();
        start_play(16'd0);
        frame = 1'b1;
        cycle();
        repeat (100) cycle();
        n_vec++;
        if (drop_cnt !== 8'd99) begin
            $display("FAIL drop_mid: dc=%0d, want 99", drop_cnt);
            n_err++;
        end
        repeat (160) cycle();
        frame = 1'b0;
        n_vec++;
        if (drop_cnt !== 8'd255 || fetch_req !== 1'b1) begin
            $display("FAIL drop_sat: dc=%0d req=%b, want 255 1", drop_cnt, fetch_req);
            n_err++;
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        fetch_ack = 1'b1;
        cycle();
        fetch_ack = 1'b0;
        repeat (3) cycle();
        n_vec++;
        if (drop_cnt !== 8'd255 || frame_cnt !== 16'd1 || state_dbg !== S_IDLE) begin
            $display("FAIL drop_hold: dc=%0d fc=%0d st=%0d, want 255 1 %0d", drop_cnt, frame_cnt, state_dbg, S_IDLE);
            n_err++;
        end
    endtask

    task automatic test_reset_midfetch();
        start_play(16'd0);
        for (int i = 0; i < 7; i++) begin
            frame = 1'b1;
            cycle();
            frame = 1'b0;
            fetch_ack = 1'b1;
            cycle();
            fetch_ack = 1'b0;
        end
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b1 || frame_cnt !== 16'd7 || fetch_idx !== 16'd7) begin
            $display("FAIL rst_pre: req=%b fc=%0d idx=%0d, want 1 7 7", fetch_req, frame_cnt, fetch_idx);
            n_err++;
        end
        #1 RST = 1'b0;
        #1;
        n_vec++;
        if (fetch_req !== 1'b0 || frame_cnt !== 16'd0 || busy !== 1'b0 || fetch_idx !== 16'd0) begin
            $display("FAIL rst_async: req=%b fc=%0d busy=%b idx=%0d, want 0 0 0 0", fetch_req, frame_cnt, busy, fetch_idx);
            n_err++;
        end
        cycle();
        RST = 1'b1;
        frame = 1'b1;
        cycle();
        frame = 1'b0;
        cycle();
        n_vec++;
        if (fetch_req !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
            $display("FAIL rst_stray: req=%b busy=%b dc=%0d, want 0 0 0", fetch_req, busy, drop_cnt);
            n_err++;
        end
        RST = 1'b0;
        cycle();
        RST = 1'b1;
        start_play(16'd0);
        n_vec++;
        if (tick_start !== 1'b1 || state_dbg !== S_RUN) begin
            $display("FAIL rst_first_cmd: ts=%b st=%0d, want 1 %0d", tick_start, state_dbg, S_RUN);
            n_err++;
        end
    endtask

    initial begin
        play = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
        frame = 1'b0;
        fetch_ack = 1'b0;
        num_frames = '0;
        test_reset();
        cycle();
        test_limit_run();
        test_overrun();
        test_tick_ack_same();
        test_pause_fetch();
        test_stop_priority();
        test_drop_saturate();
        test_reset_midfetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
